// File: rtl/rv_alu_seq_if.sv
// Issue/writeback handshake bundle for rv_alu_seq: request with operands in,
// registered result with a one-cycle valid pulse out.
interface rv_alu_seq_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic [4:0]      op_sel_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic            ready_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, op_sel_i, op1_i, op2_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, op_sel_i, op1_i, op2_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/rv_alu_seq.sv
// Execute-stage ALU: single-cycle RV64I ops plus iterative unsigned mul/div.
// Define RV_ALU_SEQ_DIV_EN to compile in the restoring divider (divu/remu).
//
// state | meaning
// IDLE  | ready; single-cycle ops complete here, multi-cycle ops start
// CALC  | busy; one mul/div iteration per cycle, XLEN iterations
// DONE  | final result registered, valid_o pulses, new request accepted
module rv_alu_seq #(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    rv_alu_seq_if.slave   bus
);
    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_XOR   = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SRL   = 5'b00101;
    localparam logic [4:0] OP_SUB   = 5'b00110;
    localparam logic [4:0] OP_SLTU  = 5'b00111;
    localparam logic [4:0] OP_SLT   = 5'b01000;
    localparam logic [4:0] OP_NOR   = 5'b01100;
    localparam logic [4:0] OP_SRA   = 5'b01101;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULHU = 5'b10001;
`ifdef RV_ALU_SEQ_DIV_EN
    localparam logic [4:0] OP_DIVU  = 5'b10100;
    localparam logic [4:0] OP_REMU  = 5'b10101;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SHW-1:0]    cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_next;
    logic [XLEN-1:0]   opnd_q;
    logic              hi_sel_q;
    logic [XLEN-1:0]   result_q;
    logic              valid_q;
    logic              ready;
    logic              accept;
    logic              last_iter;
    logic              is_multi;
    logic              multi_hi;
    logic [XLEN-1:0]   single_res;
    logic [SHW-1:0]    shamt;
    logic [XLEN:0]     mul_sum;
`ifdef RV_ALU_SEQ_DIV_EN
    logic              div_q;
    logic              multi_div;
    logic [XLEN:0]     div_trial;
`endif

    assign accept = bus.valid_i & ready;
    assign shamt  = bus.op2_i[SHW-1:0];

    always_comb begin
        is_multi = 1'b0;
        multi_hi = 1'b0;
`ifdef RV_ALU_SEQ_DIV_EN
        multi_div = 1'b0;
`endif
        case (bus.op_sel_i)
            OP_MUL:   is_multi = 1'b1;
            OP_MULHU: begin is_multi = 1'b1; multi_hi = 1'b1; end
`ifdef RV_ALU_SEQ_DIV_EN
            OP_DIVU:  begin is_multi = 1'b1; multi_div = 1'b1; end
            OP_REMU:  begin is_multi = 1'b1; multi_div = 1'b1; multi_hi = 1'b1; end
`endif
            default:  ;
        endcase
    end

    always_comb begin
        single_res = '0;
        case (bus.op_sel_i)
            OP_AND:  single_res = bus.op1_i & bus.op2_i;
            OP_OR:   single_res = bus.op1_i | bus.op2_i;
            OP_ADD:  single_res = bus.op1_i + bus.op2_i;
            OP_XOR:  single_res = bus.op1_i ^ bus.op2_i;
            OP_SUB:  single_res = bus.op1_i - bus.op2_i;
            OP_SLTU: single_res = {{(XLEN-1){1'b0}}, bus.op1_i < bus.op2_i};
            OP_SLT:  single_res = {{(XLEN-1){1'b0}}, $signed(bus.op1_i) < $signed(bus.op2_i)};
            OP_NOR:  single_res = ~(bus.op1_i | bus.op2_i);
            OP_SLL:  single_res = bus.op1_i << shamt;
            OP_SRL:  single_res = bus.op1_i >> shamt;
            OP_SRA:  single_res = $unsigned($signed(bus.op1_i) >>> shamt);
            default: single_res = '0;
        endcase
    end

    // acc_q is {hi, lo}: mul keeps partial product in hi and the multiplier in lo;
    // div keeps the remainder in hi and shifts the quotient into lo.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        if (acc_q[0]) begin
            acc_next = {mul_sum, acc_q[XLEN-1:1]};
        end else begin
            acc_next = {1'b0, acc_q[2*XLEN-1:1]};
        end
`ifdef RV_ALU_SEQ_DIV_EN
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
        if (div_q) begin
            // With a zero divisor every trial succeeds, giving all-ones and op1.
            if (!div_trial[XLEN]) begin
                acc_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready     = 1'b1;
        last_iter = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept && is_multi) begin
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                ready     = 1'b0;
                last_iter = (cnt_q == SHW'(XLEN-1));
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_sel_q <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
`ifdef RV_ALU_SEQ_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                if (is_multi) begin
                    cnt_q    <= '0;
                    hi_sel_q <= multi_hi;
`ifdef RV_ALU_SEQ_DIV_EN
                    div_q    <= multi_div;
                    acc_q    <= {{XLEN{1'b0}}, multi_div ? bus.op1_i : bus.op2_i};
                    opnd_q   <= multi_div ? bus.op2_i : bus.op1_i;
`else
                    acc_q    <= {{XLEN{1'b0}}, bus.op2_i};
                    opnd_q   <= bus.op1_i;
`endif
                end else begin
                    result_q <= single_res;
                    valid_q  <= 1'b1;
                end
            end else if (state_q == CALC) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + SHW'(1);
                if (last_iter) begin
                    result_q <= hi_sel_q ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
                    valid_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.ready_o  = ready;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
endmodule
